// File: rtl/vga_pkg.sv
// vga_pkg -- shared definitions for the VGA frame scheduler.
//   * Default 640x480@60 timing constants (pixel ticks / lines).
//   * CNT_W: width of the x/y position counters.
//   * grant_state_e: states of the framebuffer write-access grant FSM.
//   * in_range(): inclusive range decode used for the sync pulses.
package vga_pkg;

  localparam int CNT_W = 10;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int DIV_DEF      = 4;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_WAIT_VBLANK = 2'd1,
    ST_GRANT       = 2'd2
  } grant_state_e;

  // Inclusive range test on a position counter.
  function automatic logic in_range(input logic [CNT_W-1:0] v,
                                    input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) <= hi);
  endfunction

endpackage

// File: rtl/vga_frame_scheduler_pixel_tick_gen.sv
// pixel_tick_gen -- divides the system clock down to a pixel clock enable.
//   clk_i    : system clock, rising edge
//   reset_i  : asynchronous active-high reset
//   tick_o   : high for one clock every DIV clocks
// The count runs 0..DIV-1 and tick_o is a decode of count == DIV-1, so after
// reset release the first tick is the one the DIV-th rising edge consumes.
// DIV must be at least 2 for tick_o to read 0 while reset is held.
module pixel_tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  output logic tick_o
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (cnt_q == LAST) cnt_d = '0;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/vga_frame_scheduler.sv
// vga_frame_scheduler -- VGA timing generator plus framebuffer access arbiter
// for a sand-simulation engine that may only write during vertical blanking.
//
// Ports:
//   clk_i, reset_i   : system clock, asynchronous active-high reset
//   sim_req_i        : engine requests framebuffer write access
//   sim_done_i       : engine finished its pass (single-cycle pulse)
//   pixel_tick_o     : pixel clock enable (one clock every DIV clocks)
//   x_o, y_o         : pixel / line position counters
//   hsync_o, vsync_o : active-low sync, decoded from x_o/y_o
//   video_on_o       : inside the visible area
//   sim_grant_o      : engine owns the framebuffer write port
//   frame_o          : one-clock pulse when x_o/y_o wrap to 0/0
//   overrun_o        : engine still held the grant when the frame wrapped
//   dbg_state_o      : current grant FSM state (vga_pkg::grant_state_e)
//
// Build option: define VGA_OVERRUN_FLAG_EN to get a sticky overrun flag;
// otherwise overrun_o is constant 0.
//
// Access handshake: the engine raises sim_req_i and holds it until it sees
// sim_grant_o; sim_grant_o rises only inside vblank (never on the last line
// of the frame) and stays high until a sim_done_i pulse or the frame wrap,
// whichever comes first. Dropping sim_req_i before the grant withdraws the
// request; sim_done_i has no effect unless the grant is held.
module vga_frame_scheduler
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int DIV      = DIV_DEF
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             sim_req_i,
  input  logic             sim_done_i,
  output logic             pixel_tick_o,
  output logic [CNT_W-1:0] x_o,
  output logic [CNT_W-1:0] y_o,
  output logic             hsync_o,
  output logic             vsync_o,
  output logic             video_on_o,
  output logic             sim_grant_o,
  output logic             frame_o,
  output logic             overrun_o,
  output logic [1:0]       dbg_state_o
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] X_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] X_VIS    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] Y_VIS    = CNT_W'(V_ACTIVE);

  logic             tick;
  logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
  logic             frame_q;
  logic             wrap_frame;
  logic             grant_ok;
  grant_state_e     state_q;
  logic             grant_q;

  pixel_tick_gen #(.DIV(DIV)) u_tick (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .tick_o  (tick)
  );

  // Position counters; wrap_frame marks the tick that returns to 0,0.
  always_comb begin
    x_d        = x_q;
    y_d        = y_q;
    wrap_frame = 1'b0;
    if (tick) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        if (y_q == Y_LAST) begin
          y_d        = '0;
          wrap_frame = 1'b1;
        end else begin
          y_d = y_q + 1'b1;
        end
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      x_q     <= '0;
      y_q     <= '0;
      frame_q <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      frame_q <= wrap_frame;
    end
  end

  // Grant may start anywhere in vblank except the last line: there would be
  // less than one line left before the forced release at the frame wrap.
  assign grant_ok = (y_q >= Y_VIS) && (y_q != Y_LAST);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      grant_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (sim_req_i) begin
            if (grant_ok) begin
              state_q <= ST_GRANT;
              grant_q <= 1'b1;
            end else begin
              state_q <= ST_WAIT_VBLANK;
            end
          end
        end
        ST_WAIT_VBLANK: begin
          if (!sim_req_i) begin
            state_q <= ST_IDLE;
          end else if (grant_ok) begin
            state_q <= ST_GRANT;
            grant_q <= 1'b1;
          end
        end
        ST_GRANT: begin
          // A done pulse and the frame wrap in the same cycle count as done.
          if (sim_done_i || wrap_frame) begin
            state_q <= ST_IDLE;
            grant_q <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef VGA_OVERRUN_FLAG_EN
  logic overrun_q;
  logic force_exit;

  assign force_exit = (state_q == ST_GRANT) && wrap_frame && !sim_done_i;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)         overrun_q <= 1'b0;
    else if (force_exit) overrun_q <= 1'b1;
  end

  assign overrun_o = overrun_q;
`else
  assign overrun_o = 1'b0;
`endif

  assign pixel_tick_o = tick;
  assign x_o          = x_q;
  assign y_o          = y_q;
  assign frame_o      = frame_q;
  assign sim_grant_o  = grant_q;
  assign dbg_state_o  = state_q;

  assign hsync_o    = ~in_range(x_q, H_ACTIVE + H_FP, H_ACTIVE + H_FP + H_SYNC - 1);
  assign vsync_o    = ~in_range(y_q, V_ACTIVE + V_FP, V_ACTIVE + V_FP + V_SYNC - 1);
  assign video_on_o = (x_q < X_VIS) && (y_q < Y_VIS);

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// tb_vga_frame_scheduler -- directed bench for vga_frame_scheduler.
// Uses a shrunken raster so whole frames fit in a short run:
//   H: 16 active, 2 FP, 4 sync, 2 BP -> 24 ticks/line, hsync low x=18..21
//   V: 12 active, 2 FP, 2 sync, 2 BP -> 18 lines, vsync low y=14..15
//   DIV = 4 -> 24*18*4 = 1728 clocks per frame.
// Line 3 stands in for line 100, line 12 for 480, 14 for 500, 17 for 524.
module tb_vga_frame_scheduler;
  import vga_pkg::*;

  localparam int HA = 16, HF = 2, HS = 4, HB = 2;
  localparam int VA = 12, VF = 2, VS = 2, VB = 2;
  localparam int DV = 4;
  localparam int FRAME_CLKS = 24 * 18 * 4;
  localparam int BUDGET = 4000;
`ifdef VGA_OVERRUN_FLAG_EN
  localparam logic OVR_EN = 1'b1;
`else
  localparam logic OVR_EN = 1'b0;
`endif

  logic             clk, rst, sim_req, sim_done;
  logic             pixel_tick, hsync, vsync, video_on, grant, frame, overrun;
  logic [CNT_W-1:0] x, y;
  logic [1:0]       dbg_state;

  int checks = 0;
  int errors = 0;

  vga_frame_scheduler #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .DIV(DV)
  ) dut (
    .clk_i        (clk),
    .reset_i      (rst),
    .sim_req_i    (sim_req),
    .sim_done_i   (sim_done),
    .pixel_tick_o (pixel_tick),
    .x_o          (x),
    .y_o          (y),
    .hsync_o      (hsync),
    .vsync_o      (vsync),
    .video_on_o   (video_on),
    .sim_grant_o  (grant),
    .frame_o      (frame),
    .overrun_o    (overrun),
    .dbg_state_o  (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Advance to the first sample where x_o/y_o equal (tx,ty).
  task automatic wait_xy(input int tx, input int ty, input string tag);
    int n = 0;
    while (!(int'(x) == tx && int'(y) == ty) && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, !(int'(x) == tx && int'(y) == ty)}, 0);
  endtask

  initial begin
    logic [7:0] tick_hist;
    int frame_cnt, hs_low, vs_low, von_cnt, grant_cnt;
    int hs_min, hs_max, vs_min, vs_max, x_max, y_max, x_at3, x_at4;
    int n, early;
    logic prev_grant;

    rst = 1'b1; sim_req = 1'b0; sim_done = 1'b0;
    tick_hist = '0;
    frame_cnt = 0; hs_low = 0; vs_low = 0; von_cnt = 0; grant_cnt = 0;
    hs_min = 999; hs_max = -1; vs_min = 999; vs_max = -1; x_max = 0; y_max = 0;
    x_at3 = -1; x_at4 = -1;

    // Reset held for three clocks
    step(3);
    check("rst_x", x, 0);
    check("rst_y", y, 0);
    check("rst_tick", pixel_tick, 0);
    check("rst_frame", frame, 0);
    check("rst_grant", grant, 0);
    check("rst_overrun", overrun, 0);
    check("rst_state", dbg_state, ST_IDLE);
    rst = 1'b0;

    // One full frame, sampled after every rising edge
    for (int i = 1; i <= FRAME_CLKS; i++) begin
      @(negedge clk);
      if (i <= 8) tick_hist[i-1] = pixel_tick;
      if (i == 3) x_at3 = int'(x);
      if (i == 4) x_at4 = int'(x);
      if (frame) frame_cnt++;
      if (!hsync) begin
        hs_low++;
        if (y == 0 && int'(x) < hs_min) hs_min = int'(x);
        if (y == 0 && int'(x) > hs_max) hs_max = int'(x);
      end
      if (!vsync) begin
        vs_low++;
        if (int'(y) < vs_min) vs_min = int'(y);
        if (int'(y) > vs_max) vs_max = int'(y);
      end
      if (video_on) von_cnt++;
      if (grant) grant_cnt++;
      if (int'(x) > x_max) x_max = int'(x);
      if (int'(y) > y_max) y_max = int'(y);
    end
    check("tick_pattern", {24'd0, tick_hist}, 32'h44);
    check("x_before_tick", x_at3, 0);
    check("x_after_tick", x_at4, 1);
    check("frame_count", frame_cnt, 1);
    check("frame_at_wrap", frame, 1);
    check("wrap_x", x, 0);
    check("wrap_y", y, 0);
    check("x_max", x_max, 23);
    check("y_max", y_max, 17);
    check("hsync_low_clks", hs_low, 4 * 4 * 18);
    check("hsync_first_x", hs_min, 18);
    check("hsync_last_x", hs_max, 21);
    check("vsync_low_clks", vs_low, 2 * 24 * 4);
    check("vsync_first_y", vs_min, 14);
    check("vsync_last_y", vs_max, 15);
    check("video_on_clks", von_cnt, 16 * 12 * 4);
    check("no_grant_idle", grant_cnt, 0);
    step(1);
    check("frame_one_clk", frame, 0);

    // Request in active video waits for vblank, released by done
    wait_xy(0, 3, "wait_y3");
    sim_req = 1'b1;
    step(1);
    check("req_to_wait", dbg_state, ST_WAIT_VBLANK);
    check("no_grant_active", grant, 0);
    wait_xy(0, 12, "wait_y12");
    check("grant_not_yet", grant, 0);
    step(1);
    check("grant_rises", grant, 1);
    check("state_grant", dbg_state, ST_GRANT);
    sim_req = 1'b0;
    wait_xy(0, 14, "wait_y14");
    sim_done = 1'b1;
    step(1);
    sim_done = 1'b0;
    check("done_drops_grant", grant, 0);
    check("done_state_idle", dbg_state, ST_IDLE);
    check("done_no_overrun", overrun, 0);
    step(3);
    sim_done = 1'b1;
    step(1);
    sim_done = 1'b0;
    check("done_ignored_idle", dbg_state, ST_IDLE);
    check("done_ignored_grant", grant, 0);

    // Withdrawn request returns to idle
    wait_xy(0, 5, "wait_y5");
    sim_req = 1'b1;
    step(1);
    check("withdraw_wait", dbg_state, ST_WAIT_VBLANK);
    sim_req = 1'b0;
    step(1);
    check("withdraw_idle", dbg_state, ST_IDLE);

    // Request on the last line is refused until the next frame's vblank
    wait_xy(0, 17, "wait_y17");
    sim_req = 1'b1;
    step(1);
    check("last_line_wait", dbg_state, ST_WAIT_VBLANK);
    n = 0; early = 0;
    while (y != 12 && n < BUDGET) begin
      @(negedge clk);
      if (grant) early++;
      n++;
    end
    check("last_line_timeout", {31'd0, (y != 12)}, 0);
    check("last_line_no_early", early, 0);
    check("last_line_not_yet", grant, 0);
    step(1);
    check("last_line_grant", grant, 1);
    sim_req = 1'b0;

    // Done coinciding with the frame wrap: done wins, no overrun
    n = 0;
    while (!(x == 23 && y == 17 && pixel_tick) && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check("wrap_tick_timeout", {31'd0, !(x == 23 && y == 17 && pixel_tick)}, 0);
    check("coinc_grant_held", grant, 1);
    sim_done = 1'b1;
    step(1);
    sim_done = 1'b0;
    check("coinc_frame", frame, 1);
    check("coinc_grant", grant, 0);
    check("coinc_state", dbg_state, ST_IDLE);
    check("coinc_overrun", overrun, 0);

    // Request already in vblank grants directly; no done -> forced release
    wait_xy(0, 13, "wait_y13");
    sim_req = 1'b1;
    step(1);
    check("direct_grant", grant, 1);
    check("direct_state", dbg_state, ST_GRANT);
    sim_req = 1'b0;
    n = 0; prev_grant = grant;
    while (!frame && n < BUDGET) begin
      prev_grant = grant;
      @(negedge clk);
      n++;
    end
    check("force_timeout", {31'd0, !frame}, 0);
    check("force_prev_grant", prev_grant, 1);
    check("force_grant_drop", grant, 0);
    check("force_overrun", overrun, OVR_EN);
    step(20);
    check("overrun_sticky", overrun, OVR_EN);

    // Reset in the middle of a grant drops it at once
    wait_xy(0, 13, "wait_y13b");
    sim_req = 1'b1;
    step(1);
    check("pre_reset_grant", grant, 1);
    sim_req = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("reset_grant", grant, 0);
    check("reset_state", dbg_state, ST_IDLE);
    check("reset_overrun", overrun, 0);
    check("reset_x", x, 0);
    check("reset_y", y, 0);
    step(1);
    rst = 1'b0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_frame_scheduler.md
VGA_FRAME_SCHEDULER -- requirements
Module: vga_frame_scheduler

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP=16, H_SYNC=96, H_BP=48; line total 800 pixel ticks.
REQ-003 SHALL have parameters V_ACTIVE=480, V_FP=10, V_SYNC=2, V_BP=33; frame total 525 lines.
REQ-004 SHALL have parameter DIV, default 4, system clocks per pixel tick (100 MHz -> 25 MHz).
REQ-005 clk_i  input  1  system clock, rising edge.
REQ-006 reset_i  input  1  asynchronous, active-high reset.
REQ-007 sim_req_i  input  1  sand-simulation engine requests framebuffer write access.
REQ-008 sim_done_i  input  1  engine finished its update pass; single-cycle pulse.
REQ-009 pixel_tick_o  output  1  one-clk pulse every DIV clocks; pixel clock enable.
REQ-010 x_o  output  10  current horizontal pixel count, 0..799.
REQ-011 y_o  output  10  current line count, 0..524.
REQ-012 hsync_o / vsync_o  output  1 each  active-low sync.
REQ-013 video_on_o  output  1  high when x_o<640 and y_o<480.
REQ-014 sim_grant_o  output  1  engine owns framebuffer write port.
REQ-015 frame_o  output  1  one-clk pulse on the tick where x,y wrap to 0,0.
REQ-016 overrun_o  output  1  engine failed to finish within blanking.

Function
REQ-017 Divider SHALL count 0..DIV-1; pixel_tick_o high in the cycle the count equals DIV-1.
REQ-018 x_o SHALL increment only on pixel_tick_o; at 799 it SHALL wrap to 0 and y_o SHALL increment.
REQ-019 y_o at 524 with x_o wrap SHALL return to 0; frame_o asserts in that same cycle.
REQ-020 hsync_o SHALL be 0 for x_o in 656..751, else 1; vsync_o 0 for y_o in 490..491, else 1.
REQ-021 Sync and video_on_o SHALL be combinational decodes of the counter registers, same-cycle aligned with x_o/y_o.
REQ-022 Grant FSM states: IDLE, WAIT_VBLANK, GRANT.
REQ-023 IDLE -> WAIT_VBLANK on sim_req_i=1; WAIT_VBLANK -> GRANT when y_o>=480; if already in vblank with y_o<524, IDLE -> GRANT directly.
REQ-024 GRANT entry SHALL be refused on line 524 (too late); request waits for next frame.
REQ-025 sim_grant_o SHALL equal (state==GRANT), registered, asserting the cycle after the transition condition.
REQ-026 GRANT -> IDLE on sim_done_i=1; sim_done_i outside GRANT SHALL be ignored.
REQ-027 GRANT -> IDLE forcibly on frame_o; if sim_done_i coincides with frame_o, done wins and no overrun is flagged.
REQ-028 sim_req_i deasserted in WAIT_VBLANK SHALL return FSM to IDLE.

Reset
REQ-029 Reset SHALL asynchronously clear divider, x_o, y_o to 0, FSM to IDLE, sim_grant_o, frame_o, pixel_tick_o, overrun_o to 0.
REQ-030 After reset release, first pixel_tick_o SHALL occur on the DIV-th rising edge.
REQ-031 Reset mid-GRANT SHALL drop sim_grant_o immediately without flagging overrun.

Configuration
REQ-032 Macro VGA_OVERRUN_FLAG_EN defined: forced GRANT exit (REQ-027) sets overrun_o sticky until reset.
REQ-033 Macro undefined: overrun_o SHALL be tied 0 and no flag register synthesised.

Structure
REQ-034 Shared package vga_pkg SHALL hold timing constants, counter width (10), and grant FSM state enum.
REQ-035 Divider SHALL be sub-module pixel_tick_gen (clk_i, reset_i, tick_o); counters and FSM stay in top.

Verification
REQ-036 Reset held 3 clks then released -> pixel_tick_o first high on 4th rising edge, then every 4 clks.
REQ-037 Run 800*525*4 clks -> exactly one frame_o, x_o/y_o back to 0/0, hsync_o low 96 ticks per line.
REQ-038 sim_req_i=1 at y_o=100 -> sim_grant_o rises one clk after y_o becomes 480.
REQ-039 Grant held, sim_done_i pulsed at y_o=500 -> sim_grant_o falls next clk, overrun_o stays 0.
REQ-040 Grant held, no sim_done_i -> sim_grant_o falls on frame_o; overrun_o=1 only with VGA_OVERRUN_FLAG_EN.
REQ-041 sim_req_i first asserted at y_o=524 -> no grant until y_o=480 of next frame.
